viterbi_channel_injector: RTL and testbench
===========================================

# viterbi_channel_injector

Parametrised noisy-channel model placed between the convolutional encoder and the Viterbi decoder. It registers each encoded symbol and, by programmable mode, flips a masked subset of its bits: periodic bursts, pseudo-random per-symbol errors, or a single triggered burst. It also keeps saturating statistics of symbols passed, symbols corrupted and bits flipped. This lets the decoder be characterised against controlled error patterns.

## Interface
- SYM_W, 2: bits per encoded symbol (code rate 1/SYM_W)
- CNT_W, 16: width of the period, burst-length and statistics counters
- LFSR_W, 16: pseudo-random generator width (fixed polynomial below requires 16)
- SEED, 16'hACE1: LFSR reset value, must be non-zero

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous active-low
- cfg_mode  in  2  0 pass-through, 1 periodic burst, 2 random, 3 one-shot burst
- cfg_period  in  CNT_W  periodic mode: symbols per period
- cfg_burst_len  in  CNT_W  corrupted symbols per burst (modes 1, 3)
- cfg_thresh  in  LFSR_W  random mode: corrupt when LFSR value < cfg_thresh
- cfg_mask  in  SYM_W  bits XORed into a corrupted symbol
- start  in  1  one-shot trigger (mode 3), single-cycle pulse
- clr_stats  in  1  clear statistics counters
- sym_valid_i  in  1  input symbol valid
- sym_i  in  SYM_W  encoded symbol from encoder
- sym_valid_o  out  1  output symbol valid
- sym_o  out  SYM_W  (possibly corrupted) symbol to decoder
- err_o  out  1  sym_o was corrupted (error applied and cfg_mask non-zero)
- sym_cnt_o  out  CNT_W  valid symbols passed
- err_sym_cnt_o  out  CNT_W  symbols with err_o=1
- err_bit_cnt_o  out  CNT_W  total bits flipped

## Operation
- Each input symbol gets an inject decision inj. Then sym_o = sym_i ^ (inj ? cfg_mask : 0) and err_o = inj & (cfg_mask != 0).
- All state (position counter, LFSR, FSM) advances only on cycles with sym_valid_i=1.
- Mode 0: inj=0.
- Mode 1:
  - Position counter pos runs 0..cfg_period-1 and wraps to 0.
  - inj = (pos < cfg_burst_len).
  - cfg_period=0: inj=0 and pos holds 0.
  - cfg_burst_len >= cfg_period: every symbol is corrupted.
- Mode 2:
  - 16-bit Galois LFSR, mask 16'hB400. It shifts right on every valid symbol in every mode.
  - inj = (current LFSR value < cfg_thresh), evaluated before the shift.
  - cfg_thresh=0: never inject. cfg_thresh=16'hFFFF: inject on every state except 16'hFFFF.
- Mode 3, FSM IDLE/BURST:
  - IDLE + start with cfg_burst_len != 0: load rem=cfg_burst_len, go to BURST.
  - BURST: each valid symbol is corrupted and rem decrements. When rem reaches 0, return to IDLE.
  - start while in BURST is ignored. start with cfg_burst_len=0 stays in IDLE.
  - The symbol on the same cycle as an accepted start is corrupted (it is the first of the burst).
- Mode change: a registered copy of cfg_mode is compared to cfg_mode. Any difference clears pos to 0 and forces the FSM to IDLE. The LFSR is not cleared.
- Statistics:
  - Each valid symbol adds 1 to sym_cnt_o.
  - err_sym_cnt_o adds err_o.
  - err_bit_cnt_o adds popcount(cfg_mask) when inj=1.
  - All three saturate at 2**CNT_W-1.
  - clr_stats zeroes all three. If clr_stats and sym_valid_i coincide, the clear wins and that symbol is not counted.
- cfg_* other than cfg_mode are sampled on each valid symbol. Changing them mid-burst takes effect on the next symbol.

## Timing
- Latency is 1 cycle. sym_valid_o, sym_o and err_o are registered from the sym_valid_i cycle.
- When sym_valid_i=0: sym_valid_o=0, err_o=0, and sym_o holds its last value.
- Statistics outputs update 1 cycle after the counted symbol, i.e. together with sym_valid_o.
- Reset (rst=0 at a clock edge, valid at any time, including mid-burst) sets:
  - sym_valid_o=0, sym_o=0, err_o=0
  - all counters 0, pos=0
  - LFSR=SEED, FSM=IDLE, registered mode=0
- The first post-reset cycle with cfg_mode!=0 counts as a mode change. pos is still 0, so behaviour is unchanged.
- Back-to-back valid symbols are supported at 1 per clock with no stall. There is no backpressure.

## Test plan
- Mode 0, 300 consecutive symbols, cfg_mask=2'b11: sym_o==sym_i delayed 1 cycle, err_o never 1, sym_cnt_o=300, error counters 0.
- Mode 1, cfg_period=16, cfg_burst_len=2, cfg_mask=2'b01, 64 symbols: symbols 0,1,16,17,32,33,48,49 have bit0 flipped; err_sym_cnt_o=8, err_bit_cnt_o=8.
- Mode 1 with gaps in sym_valid_i (valid every 3rd cycle), period 4, burst 1: corruption follows symbol index, not clock count. Also cfg_period=0 gives no errors.
- Mode 2, cfg_thresh=16'h8000, mask 2'b11, 1000 symbols: err_o matches a reference LFSR model exactly starting from SEED; err_bit_cnt_o = 2*err_sym_cnt_o.
- Mode 3:
  - start with burst_len=5 corrupts exactly 5 valid symbols, including the start cycle.
  - A second start during the burst is ignored.
  - Switching to mode 1 mid-burst aborts the burst and restarts pos at 0.
- Boundaries:
  - CNT_W=4: counters stop at 15.
  - clr_stats coincident with a corrupted symbol leaves all counters 0.
  - rst asserted mid-burst returns all outputs and state to reset values on the next cycle.

Source files
------------

// File: rtl/viterbi_channel_injector.sv
// Noisy-channel model between the convolutional encoder and the Viterbi decoder: registers each
// symbol, XORs cfg_mask onto selected symbols (burst/random/one-shot) and keeps saturating stats.
module viterbi_channel_injector #(
    parameter int                SYM_W  = 2,
    parameter int                CNT_W  = 16,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_burst_len,
    input  logic [LFSR_W-1:0] cfg_thresh,
    input  logic [SYM_W-1:0]  cfg_mask,
    input  logic              start,
    input  logic              clr_stats,
    input  logic              sym_valid_i,
    input  logic [SYM_W-1:0]  sym_i,
    output logic              sym_valid_o,
    output logic [SYM_W-1:0]  sym_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  sym_cnt_o,
    output logic [CNT_W-1:0]  err_sym_cnt_o,
    output logic [CNT_W-1:0]  err_bit_cnt_o
);

    typedef enum logic [1:0] {
        MODE_PASS     = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_RANDOM   = 2'd2,
        MODE_ONESHOT  = 2'd3
    } mode_t;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);

    function automatic logic [CNT_W-1:0] popcount(input logic [SYM_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SYM_W; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    mode_t             mode_q;
    state_t            state_q, state_d, state_eff;
    logic [CNT_W-1:0]  pos_q, pos_d, pos_eff;
    logic [CNT_W-1:0]  rem_q, rem_d, rem_cur;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W:0]    pos_inc;
    logic              mode_chg, start_ok, inj, err_now;
    logic [CNT_W-1:0]  flip_cnt;

    logic              vld_q, err_q;
    logic [SYM_W-1:0]  sym_q;
    logic [CNT_W-1:0]  sym_cnt_q, err_sym_cnt_q, err_bit_cnt_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        inj     = 1'b0;
        pos_d   = '0;
        state_d = S_IDLE;
        rem_d   = rem_q;

        // A mode change is seen in the same cycle: the symbol then sees pos=0 and an idle FSM.
        mode_chg  = mode_t'(cfg_mode) != mode_q;
        pos_eff   = mode_chg ? '0 : pos_q;
        state_eff = mode_chg ? S_IDLE : state_q;
        pos_d     = pos_eff;
        state_d   = state_eff;
        pos_inc   = {1'b0, pos_eff} + (CNT_W+1)'(1);
        start_ok  = start && (state_eff == S_IDLE) && (cfg_burst_len != '0);
        rem_cur   = (state_eff == S_BURST) ? rem_q : cfg_burst_len;

        lfsr_d = sym_valid_i ? ({1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0)) : lfsr_q;

        case (mode_t'(cfg_mode))
            MODE_PERIODIC: begin
                inj = (cfg_period != '0) && (pos_eff < cfg_burst_len);
                if (sym_valid_i)
                    pos_d = (cfg_period == '0 || pos_inc >= {1'b0, cfg_period}) ? '0 : pos_inc[CNT_W-1:0];
            end
            MODE_RANDOM: inj = lfsr_q < cfg_thresh;
            MODE_ONESHOT: begin
                if (start_ok || state_eff == S_BURST) begin
                    inj     = 1'b1;
                    state_d = S_BURST;
                    rem_d   = rem_cur;
                    if (sym_valid_i) begin
                        rem_d = rem_cur - CNT_W'(1);
                        if (rem_cur == CNT_W'(1)) state_d = S_IDLE;
                    end
                end
            end
            default: ;
        endcase

        err_now  = inj && (cfg_mask != '0);
        flip_cnt = inj ? popcount(cfg_mask) : '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, and all state is updated with non-blocking assignments.
        if (!rst) begin
            mode_q        <= MODE_PASS;
            state_q       <= S_IDLE;
            pos_q         <= '0;
            rem_q         <= '0;
            lfsr_q        <= SEED;
            vld_q         <= 1'b0;
            err_q         <= 1'b0;
            sym_q         <= '0;
            sym_cnt_q     <= '0;
            err_sym_cnt_q <= '0;
            err_bit_cnt_q <= '0;
        end else begin
            mode_q  <= mode_t'(cfg_mode);
            state_q <= state_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            lfsr_q  <= lfsr_d;
            vld_q   <= sym_valid_i;
            err_q   <= sym_valid_i && err_now;
            if (sym_valid_i) sym_q <= sym_i ^ (inj ? cfg_mask : '0);
            // Clear beats a coincident symbol, which is then not counted.
            if (clr_stats) begin
                sym_cnt_q     <= '0;
                err_sym_cnt_q <= '0;
                err_bit_cnt_q <= '0;
            end else if (sym_valid_i) begin
                sym_cnt_q     <= sat_add(sym_cnt_q, CNT_W'(1));
                err_sym_cnt_q <= sat_add(err_sym_cnt_q, CNT_W'(err_now));
                err_bit_cnt_q <= sat_add(err_bit_cnt_q, flip_cnt);
            end
        end
    end

    assign sym_valid_o   = vld_q;
    assign sym_o         = sym_q;
    assign err_o         = err_q;
    assign sym_cnt_o     = sym_cnt_q;
    assign err_sym_cnt_o = err_sym_cnt_q;
    assign err_bit_cnt_o = err_bit_cnt_q;

endmodule

// File: tb/tb_viterbi_channel_injector.sv
// Bench for viterbi_channel_injector: randomized and directed stimulus against a symbol-level model;
// a second instance with 4-bit counters, fixed in random mode, exercises counter saturation.
module tb_viterbi_channel_injector;

    localparam int SYM_W = 2;
    localparam int CNT_W = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clr_stats, sym_valid_i;
    logic [1:0]  cfg_mode, cfg_mask, sym_i;
    logic [15:0] cfg_period, cfg_burst_len, cfg_thresh;

    logic        sym_valid_o, err_o;
    logic [1:0]  sym_o;
    logic [15:0] sym_cnt_o, err_sym_cnt_o, err_bit_cnt_o;

    logic        v4, e4;
    logic [1:0]  s4;
    logic [3:0]  sc4, esc4, ebc4;

    viterbi_channel_injector #(.SYM_W(SYM_W), .CNT_W(CNT_W), .LFSR_W(16), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_burst_len(cfg_burst_len), .cfg_thresh(cfg_thresh), .cfg_mask(cfg_mask),
        .start(start), .clr_stats(clr_stats), .sym_valid_i(sym_valid_i), .sym_i(sym_i),
        .sym_valid_o(sym_valid_o), .sym_o(sym_o), .err_o(err_o), .sym_cnt_o(sym_cnt_o),
        .err_sym_cnt_o(err_sym_cnt_o), .err_bit_cnt_o(err_bit_cnt_o)
    );

    viterbi_channel_injector #(.SYM_W(SYM_W), .CNT_W(4), .LFSR_W(16), .SEED(SEED)) dut4 (
        .clk(clk), .rst(rst), .cfg_mode(2'd2), .cfg_period(4'd0),
        .cfg_burst_len(4'd0), .cfg_thresh(16'hFFFF), .cfg_mask(2'b11),
        .start(start), .clr_stats(clr_stats), .sym_valid_i(sym_valid_i), .sym_i(sym_i),
        .sym_valid_o(v4), .sym_o(s4), .err_o(e4), .sym_cnt_o(sc4),
        .err_sym_cnt_o(esc4), .err_bit_cnt_o(ebc4)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: symbol index since entering mode 1, remaining burst symbols in mode 3.
    logic [15:0] m_lfsr;
    int          m_mode_prev, m_idx, m_burst_left;
    longint      m_sym, m_esym, m_ebit, m4_sym, m4_es, m4_eb;
    logic        e_vld, e_err, e4_err;
    logic [1:0]  e_sym, e4_sym;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] sat(input longint v, input longint mx);
        return 64'((v > mx) ? mx : v);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_eval();
        logic inj, inj4;
        if (!rst) begin
            m_lfsr = SEED; m_mode_prev = 0; m_idx = 0; m_burst_left = 0;
            m_sym = 0; m_esym = 0; m_ebit = 0; m4_sym = 0; m4_es = 0; m4_eb = 0;
            e_vld = 1'b0; e_err = 1'b0; e_sym = 2'b00; e4_err = 1'b0; e4_sym = 2'b00;
            return;
        end
        if (int'(cfg_mode) != m_mode_prev) begin
            m_idx = 0;
            m_burst_left = 0;
        end
        m_mode_prev = int'(cfg_mode);
        inj = 1'b0;
        case (cfg_mode)
            2'd1: inj = (cfg_period != 0) && ((m_idx % int'(cfg_period)) < int'(cfg_burst_len));
            2'd2: inj = m_lfsr < cfg_thresh;
            2'd3: begin
                if (m_burst_left == 0 && start && cfg_burst_len != 0) m_burst_left = int'(cfg_burst_len);
                inj = m_burst_left > 0;
            end
            default: inj = 1'b0;
        endcase
        inj4   = m_lfsr != 16'hFFFF;
        e_vld  = sym_valid_i;
        e_err  = sym_valid_i && inj && (cfg_mask != 0);
        e4_err = sym_valid_i && inj4;
        if (sym_valid_i) begin
            e_sym  = sym_i ^ (inj ? cfg_mask : 2'b00);
            e4_sym = sym_i ^ (inj4 ? 2'b11 : 2'b00);
            if (cfg_mode == 2'd1) m_idx++;
            if (cfg_mode == 2'd3 && m_burst_left > 0) m_burst_left--;
            m_lfsr = lfsr_next(m_lfsr);
        end
        if (clr_stats) begin
            m_sym = 0; m_esym = 0; m_ebit = 0; m4_sym = 0; m4_es = 0; m4_eb = 0;
        end else if (sym_valid_i) begin
            m_sym++;
            if (inj && cfg_mask != 0) m_esym++;
            if (inj) m_ebit += $countones(cfg_mask);
            m4_sym++;
            if (inj4) begin
                m4_es++;
                m4_eb += 2;
            end
        end
    endtask

    task automatic compare_all();
        check("sym_valid_o", 64'(sym_valid_o), 64'(e_vld));
        check("sym_o", 64'(sym_o), 64'(e_sym));
        check("err_o", 64'(err_o), 64'(e_err));
        check("sym_cnt_o", 64'(sym_cnt_o), sat(m_sym, 65535));
        check("err_sym_cnt_o", 64'(err_sym_cnt_o), sat(m_esym, 65535));
        check("err_bit_cnt_o", 64'(err_bit_cnt_o), sat(m_ebit, 65535));
        check("w4_sym_valid_o", 64'(v4), 64'(e_vld));
        check("w4_sym_o", 64'(s4), 64'(e4_sym));
        check("w4_err_o", 64'(e4), 64'(e4_err));
        check("w4_sym_cnt_o", 64'(sc4), sat(m4_sym, 15));
        check("w4_err_sym_cnt_o", 64'(esc4), sat(m4_es, 15));
        check("w4_err_bit_cnt_o", 64'(ebc4), sat(m4_eb, 15));
    endtask

    // One clock: model consumes the current inputs, DUT outputs are compared 1 ns after the edge.
    task automatic sym_cycle(input bit v);
        sym_valid_i = v;
        sym_i = 2'($urandom);
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        start = 1'b0;
        clr_stats = 1'b0;
        rst = 1'b1;
    endtask

    // Idle cycle that switches mode/config and clears statistics.
    task automatic reconfig(input logic [1:0] mode, input logic [15:0] period,
                            input logic [15:0] burst, input logic [1:0] mask);
        cfg_mode = 2'd0;
        sym_cycle(1'b0);
        cfg_mode = mode; cfg_period = period; cfg_burst_len = burst; cfg_mask = mask;
        clr_stats = 1'b1;
        sym_cycle(1'b0);
    endtask

    initial begin
        logic [15:0] es_before;
        int cur_mode;
        rst = 1'b0; start = 1'b0; clr_stats = 1'b0; sym_valid_i = 1'b0; sym_i = 2'b00;
        cfg_mode = 2'd0; cfg_mask = 2'b00; cfg_period = 16'd0; cfg_burst_len = 16'd0; cfg_thresh = 16'd0;
        @(negedge clk);
        rst = 1'b0; sym_cycle(1'b1);
        rst = 1'b0; sym_cycle(1'b0);
        check("reset_sym_valid_o", 64'(sym_valid_o), 64'd0);
        check("reset_sym_cnt_o", 64'(sym_cnt_o), 64'd0);

        // Pass-through
        reconfig(2'd0, 16'd0, 16'd0, 2'b11);
        for (int i = 0; i < 300; i++) sym_cycle(1'b1);
        check("mode0_sym_cnt", 64'(sym_cnt_o), 64'd300);
        check("mode0_err_sym_cnt", 64'(err_sym_cnt_o), 64'd0);
        check("mode0_err_bit_cnt", 64'(err_bit_cnt_o), 64'd0);
        check("w4_sym_cnt_saturated", 64'(sc4), 64'd15);
        check("w4_err_bit_cnt_saturated", 64'(ebc4), 64'd15);

        // Periodic bursts, back to back
        reconfig(2'd1, 16'd16, 16'd2, 2'b01);
        for (int i = 0; i < 64; i++) sym_cycle(1'b1);
        check("mode1_err_sym_cnt", 64'(err_sym_cnt_o), 64'd8);
        check("mode1_err_bit_cnt", 64'(err_bit_cnt_o), 64'd8);

        // Periodic with gaps: follows symbol index, not clock count
        reconfig(2'd1, 16'd4, 16'd1, 2'b11);
        for (int i = 0; i < 40; i++) sym_cycle(i % 3 == 0);
        check("gap_sym_cnt", 64'(sym_cnt_o), 64'd14);
        check("gap_err_sym_cnt", 64'(err_sym_cnt_o), 64'd4);
        check("gap_err_bit_cnt", 64'(err_bit_cnt_o), 64'd8);
        reconfig(2'd1, 16'd0, 16'd3, 2'b11);
        for (int i = 0; i < 20; i++) sym_cycle(1'b1);
        check("period0_sym_cnt", 64'(sym_cnt_o), 64'd20);
        check("period0_err_sym_cnt", 64'(err_sym_cnt_o), 64'd0);

        // Random mode: first LFSR states from SEED are ACE1, E270, 7138
        rst = 1'b0; sym_cycle(1'b0);
        cfg_thresh = 16'hACE2;
        reconfig(2'd2, 16'd0, 16'd0, 2'b11);
        sym_cycle(1'b1); check("lfsr_pin0", 64'(err_o), 64'd1);
        sym_cycle(1'b1); check("lfsr_pin1", 64'(err_o), 64'd0);
        sym_cycle(1'b1); check("lfsr_pin2", 64'(err_o), 64'd1);
        rst = 1'b0; sym_cycle(1'b0);
        cfg_thresh = 16'h8000;
        reconfig(2'd2, 16'd0, 16'd0, 2'b11);
        for (int i = 0; i < 1000; i++) sym_cycle(1'b1);
        check("mode2_bits_twice_syms", 64'(err_bit_cnt_o), 64'(2 * m_esym));

        // One-shot burst with an ignored second start
        reconfig(2'd3, 16'd0, 16'd5, 2'b10);
        start = 1'b1; sym_cycle(1'b1);
        sym_cycle(1'b1);
        start = 1'b1; sym_cycle(1'b1);
        for (int i = 0; i < 10; i++) sym_cycle(1'b1);
        check("oneshot_err_sym_cnt", 64'(err_sym_cnt_o), 64'd5);
        check("oneshot_err_bit_cnt", 64'(err_bit_cnt_o), 64'd5);

        // Abort a burst by switching to mode 1
        clr_stats = 1'b1; cfg_burst_len = 16'd6; sym_cycle(1'b0);
        start = 1'b1; sym_cycle(1'b1);
        sym_cycle(1'b1); sym_cycle(1'b1);
        cfg_mode = 2'd1; cfg_period = 16'd8; cfg_burst_len = 16'd2;
        for (int i = 0; i < 10; i++) sym_cycle(1'b1);
        check("abort_err_sym_cnt", 64'(err_sym_cnt_o), 64'd7);

        // Clear coincident with a corrupted symbol
        reconfig(2'd1, 16'd4, 16'd4, 2'b11);
        for (int i = 0; i < 5; i++) sym_cycle(1'b1);
        clr_stats = 1'b1; sym_cycle(1'b1);
        check("clr_coincident_err_o", 64'(err_o), 64'd1);
        check("clr_coincident_sym_cnt", 64'(sym_cnt_o), 64'd0);
        check("clr_coincident_err_sym_cnt", 64'(err_sym_cnt_o), 64'd0);
        check("clr_coincident_err_bit_cnt", 64'(err_bit_cnt_o), 64'd0);

        // Reset in the middle of a burst
        reconfig(2'd3, 16'd0, 16'd10, 2'b11);
        start = 1'b1; sym_cycle(1'b1);
        for (int i = 0; i < 3; i++) sym_cycle(1'b1);
        rst = 1'b0; start = 1'b1; sym_cycle(1'b1);
        check("midburst_rst_valid", 64'(sym_valid_o), 64'd0);
        check("midburst_rst_sym", 64'(sym_o), 64'd0);
        check("midburst_rst_err", 64'(err_o), 64'd0);
        check("midburst_rst_err_sym_cnt", 64'(err_sym_cnt_o), 64'd0);
        es_before = err_sym_cnt_o;
        for (int i = 0; i < 5; i++) sym_cycle(1'b1);
        check("post_rst_idle", 64'(err_sym_cnt_o), 64'(es_before));

        // Randomized epochs
        cur_mode = int'(cfg_mode);
        for (int ep = 0; ep < 24; ep++) begin
            int nm;
            nm = $urandom_range(0, 3);
            if (!(nm == 1 && cur_mode == 1)) begin
                cfg_period    = 16'($urandom_range(0, 12));
                cfg_burst_len = 16'($urandom_range(0, 14));
            end
            cfg_mode   = 2'(nm);
            cfg_thresh = 16'($urandom);
            cfg_mask   = 2'($urandom);
            cur_mode   = nm;
            for (int i = 0; i < 100; i++) begin
                start     = ($urandom_range(0, 15) == 0);
                clr_stats = ($urandom_range(0, 63) == 0);
                rst       = ($urandom_range(0, 499) != 0);
                if (!rst) cur_mode = -1;
                sym_cycle($urandom_range(0, 3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
